// File: rtl/mips_check_pkg.sv
// Shared types for the MIPS data-memory write checker.
package mips_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } check_state_t;

  typedef enum logic [2:0] {
    FC_NONE    = 3'd0,
    FC_ADDR    = 3'd1,
    FC_DATA    = 3'd2,
    FC_TIMEOUT = 3'd3,
    FC_EMPTY   = 3'd4
  } fail_code_t;

  // Index width for an n-entry array, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memwrite_exp_table.sv
// Expected-store table: append-only register file with entry count,
// full flag and a combinational read port addressed by the check pointer.
module memwrite_exp_table
  import mips_check_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       we,
  input  logic [WIDTH-1:0]           wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [$clog2(DEPTH+1)-1:0] rd_ptr,
  output logic [WIDTH-1:0]           rd_addr,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = idx_width(DEPTH);

  logic [WIDTH-1:0] addr_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             wr_en_c;

  // Appends are dropped once the table holds DEPTH entries.
  always_comb begin
    count_d = count_q;
    wr_en_c = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (we && (count_q < CNT_W'(DEPTH))) begin
      wr_en_c = 1'b1;
      count_d = CNT_W'(count_q + CNT_W'(1));
    end
    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Storage needs no reset: entries beyond count are never read.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      addr_mem[IDX_W'(count_q)] <= wr_addr;
      data_mem[IDX_W'(count_q)] <= wr_data;
    end
  end

  assign rd_addr = addr_mem[IDX_W'(rd_ptr)];
  assign rd_data = data_mem[IDX_W'(rd_ptr)];
  assign count   = count_q;
  assign full    = full_q;

endmodule

// File: rtl/memwrite_checker.sv
// In-order checker for the data-memory store port: compares each store
// against a loaded table, tolerates a scratch window, and latches a verdict.
module memwrite_checker
  import mips_check_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned SCRATCH_LO = 80,
  parameter int unsigned SCRATCH_HI = 80
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       exp_we,
  input  logic [WIDTH-1:0]           exp_addr,
  input  logic [WIDTH-1:0]           exp_data,
  input  logic                       start,
  input  logic                       memwrite,
  input  logic [WIDTH-1:0]           dataadr,
  input  logic [WIDTH-1:0]           writedata,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic [2:0]                 fail_code,
  output logic [$clog2(DEPTH+1)-1:0] match_count,
  output logic                       table_full
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  check_state_t     state_q, state_d;
  fail_code_t       code_q, code_d;
  logic [CNT_W-1:0] ptr_q, ptr_d;
  logic [TMO_W-1:0] cyc_q, cyc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;

  logic             tbl_we_c;
  logic [WIDTH-1:0] cur_addr_c;
  logic [WIDTH-1:0] cur_data_c;
  logic [CNT_W-1:0] tbl_count;
  logic             tbl_full;
  logic             addr_hit_c;
  logic             data_hit_c;
  logic             in_scratch_c;
  logic             final_match_c;

  memwrite_exp_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .we      (tbl_we_c),
    .wr_addr (exp_addr),
    .wr_data (exp_data),
    .rd_ptr  (ptr_q),
    .rd_addr (cur_addr_c),
    .rd_data (cur_data_c),
    .count   (tbl_count),
    .full    (tbl_full)
  );

  assign addr_hit_c   = (dataadr == cur_addr_c);
  assign data_hit_c   = (writedata == cur_data_c);
  assign in_scratch_c = (dataadr >= WIDTH'(SCRATCH_LO)) && (dataadr <= WIDTH'(SCRATCH_HI));

  // Next-state, pointer, cycle counter and verdict code.
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    ptr_d         = ptr_q;
    cyc_d         = cyc_q;
    tbl_we_c      = 1'b0;
    final_match_c = 1'b0;

    if (clear) begin
      state_d = IDLE;
      code_d  = FC_NONE;
      ptr_d   = '0;
      cyc_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ptr_d = '0;
            cyc_d = '0;
            if (tbl_count == '0) begin
              state_d = FAIL;
              code_d  = FC_EMPTY;
            end else begin
              state_d = RUN;
            end
          end else begin
            tbl_we_c = exp_we;
          end
        end

        RUN: begin
          cyc_d = TMO_W'(cyc_q + TMO_W'(1));
          if (memwrite) begin
            if (addr_hit_c && data_hit_c) begin
              ptr_d = CNT_W'(ptr_q + CNT_W'(1));
              if (ptr_d == tbl_count) begin
                final_match_c = 1'b1;
                state_d       = PASS;
              end
            end else if (addr_hit_c) begin
              state_d = FAIL;
              code_d  = FC_DATA;
            end else if (!in_scratch_c) begin
              state_d = FAIL;
              code_d  = FC_ADDR;
            end
          end
          // A final match on the timeout edge still counts as a pass.
          if ((cyc_d == TMO_W'(TIMEOUT)) && !final_match_c) begin
            state_d = FAIL;
            code_d  = FC_TIMEOUT;
          end
        end

        PASS, FAIL: begin
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == RUN);
    pass_d = (state_d == PASS);
    fail_d = (state_d == FAIL);
    done_d = pass_d || fail_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= FC_NONE;
      ptr_q   <= '0;
      cyc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_code   = code_q;
  assign match_count = ptr_q;
  assign table_full  = tbl_full;

endmodule

// File: tb/tb_memwrite_checker.sv
// Directed and randomized bench for memwrite_checker against a queue-based
// model of the expected-store list and verdict rules.
module tb_memwrite_checker;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned SLO     = 80;
  localparam int unsigned SHI     = 80;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic             exp_we = 1'b0;
  logic [WIDTH-1:0] exp_addr = '0;
  logic [WIDTH-1:0] exp_data = '0;
  logic             start = 1'b0;
  logic             memwrite = 1'b0;
  logic [WIDTH-1:0] dataadr = '0;
  logic [WIDTH-1:0] writedata = '0;
  logic             busy, done, pass, fail, table_full;
  logic [2:0]       fail_code;
  logic [3:0]       match_count;

  memwrite_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT),
    .SCRATCH_LO(SLO), .SCRATCH_HI(SHI)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_code(fail_code), .match_count(match_count), .table_full(table_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: list of expected stores plus a verdict summary.
  logic [WIDTH-1:0] q_a[$];
  logic [WIDTH-1:0] q_d[$];
  bit               m_running, m_pass, m_fail;
  int               m_code, m_matched, m_cycles;

  task automatic model_reset();
    q_a.delete(); q_d.delete();
    m_running = 0; m_pass = 0; m_fail = 0;
    m_code = 0; m_matched = 0; m_cycles = 0;
  endtask

  task automatic model_step();
    bit finished;
    if (clear) begin
      model_reset();
    end else if (m_running) begin
      finished = 0;
      m_cycles++;
      if (memwrite) begin
        if (dataadr == q_a[m_matched] && writedata == q_d[m_matched]) begin
          m_matched++;
          if (m_matched == q_a.size()) begin
            finished = 1; m_running = 0; m_pass = 1;
          end
        end else if (dataadr == q_a[m_matched]) begin
          m_running = 0; m_fail = 1; m_code = 2;
        end else if (!(dataadr >= SLO && dataadr <= SHI)) begin
          m_running = 0; m_fail = 1; m_code = 1;
        end
      end
      if (m_cycles == TIMEOUT && !finished) begin
        m_running = 0; m_fail = 1; m_code = 3;
      end
    end else if (!m_pass && !m_fail) begin
      if (start) begin
        m_matched = 0; m_cycles = 0;
        if (q_a.size() == 0) begin
          m_fail = 1; m_code = 4;
        end else begin
          m_running = 1;
        end
      end else if (exp_we && q_a.size() < DEPTH) begin
        q_a.push_back(exp_addr);
        q_d.push_back(exp_data);
      end
    end
  endtask

  task automatic chk(input string tag, input string sig, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, sig, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "busy", int'(busy), int'(m_running));
    chk(tag, "done", int'(done), int'(m_pass || m_fail));
    chk(tag, "pass", int'(pass), int'(m_pass));
    chk(tag, "fail", int'(fail), int'(m_fail));
    chk(tag, "fail_code", int'(fail_code), m_code);
    chk(tag, "match_count", int'(match_count), m_matched);
    chk(tag, "table_full", int'(table_full), int'(q_a.size() == DEPTH));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    clear = 0; exp_we = 0; start = 0; memwrite = 0;
  endtask

  task automatic load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
    exp_we = 1; exp_addr = a; exp_data = d;
    tick("load");
  endtask

  task automatic store(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
    memwrite = 1; dataadr = a; writedata = d;
    tick(tag);
  endtask

  task automatic do_clear();
    clear = 1;
    tick("clear");
  endtask

  task automatic do_start(input string tag);
    start = 1;
    tick(tag);
  endtask

  task automatic lbu_pass(input string tag);
    load(84, 32'hFFFF7F02);
    do_start(tag);
    store(tag, 80, 32'h0000_0002);
    store(tag, 84, 32'hFFFF7F02);
    chk(tag, "pass_direct", int'(pass), 1);
    chk(tag, "mc_direct", int'(match_count), 1);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 0;

    // lbu program, then post-verdict stores are ignored
    lbu_pass("lbu");
    store("lbu_sticky", 92, 32'h1);
    tick("lbu_sticky");

    // bad data
    do_clear();
    load(84, 32'hFFFF7F02);
    do_start("bad_data");
    store("bad_data", 84, 32'h0000_00FF);
    chk("bad_data", "code_direct", int'(fail_code), 2);

    // bad address after one match
    do_clear();
    load(84, 5);
    load(88, 7);
    do_start("bad_addr");
    store("bad_addr", 84, 5);
    store("bad_addr", 92, 7);
    chk("bad_addr", "code_direct", int'(fail_code), 1);
    chk("bad_addr", "mc_direct", int'(match_count), 1);

    // timeout: 16 edges after busy rises
    do_clear();
    load(84, 1);
    do_start("timeout");
    for (int i = 0; i < 15; i++) tick("timeout_wait");
    chk("timeout", "busy_15", int'(busy), 1);
    tick("timeout");
    chk("timeout", "code_direct", int'(fail_code), 3);

    // final match on the 16th edge wins
    do_clear();
    load(84, 1);
    do_start("tmo_match");
    for (int i = 0; i < 15; i++) tick("tmo_match_wait");
    store("tmo_match", 84, 1);
    chk("tmo_match", "pass_direct", int'(pass), 1);

    // empty table
    do_clear();
    do_start("empty");
    chk("empty", "code_direct", int'(fail_code), 4);

    // overfill: 9th entry dropped
    do_clear();
    for (int i = 0; i < 9; i++) load(WIDTH'(100 + 4 * i), WIDTH'(i + 1));
    chk("full", "full_direct", int'(table_full), 1);
    do_start("full");
    for (int i = 0; i < 8; i++) store("full_run", WIDTH'(100 + 4 * i), WIDTH'(i + 1));
    chk("full", "pass_direct", int'(pass), 1);
    chk("full", "mc_direct", int'(match_count), 8);

    // start beats exp_we
    do_clear();
    load(84, 1);
    start = 1; exp_we = 1; exp_addr = 88; exp_data = 2;
    tick("start_we");
    store("start_we", 84, 1);
    chk("start_we", "pass_direct", int'(pass), 1);

    // asynchronous reset mid-run, then reload
    do_clear();
    load(84, 5);
    load(88, 7);
    do_start("async_rst");
    store("async_rst", 84, 5);
    #2 reset = 1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 0;
    lbu_pass("after_rst");

    // clear mid-run
    do_clear();
    load(84, 5);
    load(88, 7);
    do_start("clear_run");
    store("clear_run", 84, 5);
    do_clear();
    lbu_pass("after_clr");

    // randomized scenarios
    for (int s = 0; s < 40; s++) begin
      int n;
      do_clear();
      n = $urandom_range(0, 9);
      for (int i = 0; i < n; i++) load($urandom & 32'h0000_FFFC, $urandom);
      do_start("rnd_start");
      for (int c = 0; c < 20 && m_running; c++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r <= 4)      store("rnd", q_a[m_matched], q_d[m_matched]);
        else if (r == 5) store("rnd", 80, $urandom);
        else if (r == 6) store("rnd", q_a[m_matched], q_d[m_matched] ^ ($urandom | 1));
        else if (r == 7) store("rnd", $urandom, $urandom);
        else             tick("rnd_idle");
      end
      if (m_running) tick("rnd_overrun");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound in case the run stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memwrite_checker.md
# memwrite_checker

Synthesizable self-checking monitor for the MIPS lab processor's data-memory write port; the parametrised successor of the per-program pass/fail benches. It holds a loadable table of up to DEPTH expected (address, data) stores and watches `memwrite`/`dataadr`/`writedata` from `top`. It checks that the stores occur in order, tolerates writes to a scratch address window, enforces a cycle timeout, and latches a sticky verdict with a failure code. One instance serves every instruction test (lbu, jr, sw, …) in simulation and on FPGA.

## Interface
- `WIDTH`, 32: address/data width.
- `DEPTH`, 8: maximum number of expected stores.
- `TIMEOUT`, 1024: RUN cycles allowed before a timeout fail.
- `SCRATCH_LO`, 80: lowest tolerated non-checked store address (inclusive).
- `SCRATCH_HI`, 80: highest tolerated non-checked store address (inclusive).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE.
- `clear`  in  1  synchronous return to IDLE; empties the table and zeroes the counters.
- `exp_we`  in  1  appends (`exp_addr`, `exp_data`) to the table; honoured in IDLE only.
- `exp_addr`  in  WIDTH  expected store address.
- `exp_data`  in  WIDTH  expected store data.
- `start`  in  1  begins checking; honoured in IDLE only.
- `memwrite`  in  1  DUT store strobe.
- `dataadr`  in  WIDTH  DUT store address.
- `writedata`  in  WIDTH  DUT store data.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in PASS or FAIL.
- `pass`  out  1  high in PASS.
- `fail`  out  1  high in FAIL.
- `fail_code`  out  3  0 none, 1 bad address, 2 bad data, 3 timeout, 4 empty table.
- `match_count`  out  $clog2(DEPTH+1)  expected stores matched so far.
- `table_full`  out  1  entry count equals DEPTH.

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE, `exp_we`:
  - count < DEPTH: write the entry at index count, then count+1.
  - count == DEPTH: ignore the write; the table stays unchanged.
- IDLE, `start`:
  - count == 0: go to FAIL with code 4.
  - otherwise: go to RUN with ptr = 0 and cycle counter = 0.
  - `start` beats `exp_we` in the same cycle; that `exp_we` is dropped.
- RUN, each edge with `memwrite`=1, evaluated in priority order:
  1. `dataadr`==exp_addr[ptr] and `writedata`==exp_data[ptr]: match. ptr+1. If ptr was count-1, go to PASS.
  2. `dataadr`==exp_addr[ptr] with a data mismatch: FAIL, code 2.
  3. SCRATCH_LO ≤ `dataadr` ≤ SCRATCH_HI: ignore.
  4. Anything else: FAIL, code 1.
- Address comparisons are unsigned over the full WIDTH bits. Data comparison is exact.
- RUN, `memwrite`=0: no check is made.
- Timeout: the cycle counter increments every RUN cycle. On the edge where it would reach TIMEOUT, the block goes to FAIL with code 3, unless a final match happens on that same edge, in which case it goes to PASS.
- PASS and FAIL are sticky; only `clear` or `reset` leaves them. DUT activity after the verdict is ignored. `exp_we` and `start` are ignored outside IDLE.
- `clear` has priority over all other inputs in every state.
- `reset` or `clear` mid-RUN abandons the check: table count 0, ptr 0, counters 0.
- Reset values: `busy`=0, `done`=0, `pass`=0, `fail`=0, `fail_code`=0, `match_count`=0, `table_full`=0. State is IDLE. Table contents are don't-care.

## Timing
- The DUT strobe is sampled at the rising edge. `memwrite`/`dataadr`/`writedata` must be stable before that edge, which is the case for the single-cycle datapath.
- Verdict latency is 1 edge. The offending or final store sampled at edge k shows `done` after edge k, i.e. visible throughout cycle k+1.
- `start` at edge k gives `busy` after edge k. The first store checked is the one at edge k+1.
- `match_count` updates on the same edge as the matching store.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `mips_check_pkg`:
  - `check_state_t` enum {IDLE, RUN, PASS, FAIL}.
  - `fail_code_t` enum, 3 bits: FC_NONE, FC_ADDR, FC_DATA, FC_TIMEOUT, FC_EMPTY.
- Sub-module `memwrite_exp_table`: DEPTH×(2·WIDTH) register file with a write port, a count/full flag, and a combinational read at ptr.
- The top-level FSM, comparators and counters live in `memwrite_checker`.

## Test plan
- lbu program: load {(84, 32'hFFFF7F02)}, start; DUT stores 80 then 84/32'hFFFF7F02 → `pass` one edge after the 84 store; `match_count`=1.
- Bad data: same table; DUT stores 84/32'h000000FF → `fail`, `fail_code`=2.
- Bad address: table {(84, 5), (88, 7)}; DUT stores 84/5 then 92/7 → `fail`, code 1, `match_count`=1.
- Timeout: TIMEOUT=16, table {(84, 1)}, no stores → `fail`, code 3, exactly 16 edges after `busy` rises. Also: a final match on the 16th edge → `pass`.
- Table limits: start with an empty table → code 4. Write 9 entries with DEPTH=8 → `table_full`=1 and the 9th entry is dropped. `start` and `exp_we` in the same cycle → the entry is not stored.
- Reset/clear mid-RUN: assert `reset` asynchronously between edges → all outputs 0 immediately. After reload and restart, the lbu scenario passes.
